life_engine: RTL and testbench

- Parametrised Conway Game-of-Life generation engine; successor to the fixed 16x16 generator.
- Holds a ROWS x COLS cell grid, loads a seed, and advances one generation per enabled clock.
- Supports free-run, single-step, a generation limit and still-life detection.
- Feeds the display/readout logic via `grid` and `gen_count`.

---
 rtl/life_engine.sv | 163 ++++++++++++++++
 tb/tb_life_engine.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/life_engine.sv
// Parametrised Game-of-Life generation engine: B3/S23 rule over a ROWS x COLS grid,
// with load, free-run, single-step, generation limit and still-life stop.
module life_engine #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int WRAP  = 1,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 start,
  input  logic                 step,
  input  logic [CNT_W-1:0]     gen_limit,
  output logic [ROWS*COLS-1:0] grid,
  output logic [CNT_W-1:0]     gen_count,
  output logic                 en,
  output logic                 busy,
  output logic                 done,
  output logic                 stable
);

  localparam int N = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Cell lookup with either toroidal wrap or a dead border outside the grid.
  function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c);
    logic [N-1:0] sh;
    logic         v;
    int           rr;
    int           cc;
    v  = 1'b0;
    sh = '0;
    if (WRAP != 0) begin
      rr = (r + ROWS) % ROWS;
      cc = (c + COLS) % COLS;
      sh = g >> (rr * COLS + cc);
      v  = sh[0];
    end else if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
      sh = g >> (r * COLS + c);
      v  = sh[0];
    end else begin
      v = 1'b0;
    end
    return v;
  endfunction

  function automatic logic [N-1:0] life_next(input logic [N-1:0] g);
    logic [N-1:0] nx;
    logic [3:0]   n;
    logic         alive;
    nx = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              n = n + {3'b000, cell_at(g, r + dr, c + dc)};
            end else begin
              n = n;
            end
          end
        end
        alive = (n == 4'd3) || (cell_at(g, r, c) && (n == 4'd2));
        nx    = nx | ({{(N-1){1'b0}}, alive} << (r * COLS + c));
      end
    end
    return nx;
  endfunction

  state_t           state_q;
  logic [N-1:0]     grid_q;
  logic [CNT_W-1:0] gen_count_q;
  logic             stable_q;

  logic [N-1:0]     next_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             same_s;
  logic             term_s;
  logic             adv_s;

  assign next_s    = life_next(grid_q);
  assign same_s    = (next_s == grid_q);
  assign cnt_inc_s = (&gen_count_q) ? gen_count_q
                                    : gen_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign term_s    = same_s || ((gen_limit != '0) && (cnt_inc_s == gen_limit));

  // Advance decision; reset and clear suppress it in the same cycle.
  always_comb begin
    adv_s = 1'b0;
    if (reset && !clear) begin
      case (state_q)
        IDLE, PAUSE: adv_s = !load && step && !start;
        RUN:         adv_s = start;
        default:     adv_s = 1'b0;
      endcase
    end else begin
      adv_s = 1'b0;
    end
  end

  // Control FSM together with grid, counter and stable-flag registers.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state_q     <= IDLE;
      grid_q      <= '0;
      gen_count_q <= '0;
      stable_q    <= 1'b0;
    end else begin
      if (adv_s) begin
        grid_q      <= next_s;
        gen_count_q <= cnt_inc_s;
        stable_q    <= same_s;
      end
      case (state_q)
        IDLE, PAUSE: begin
          if (load) begin
            grid_q      <= seed;
            gen_count_q <= '0;
            stable_q    <= 1'b0;
          end else if (start) begin
            state_q <= RUN;
          end else if (step) begin
            state_q <= term_s ? DONE : PAUSE;
          end
        end
        RUN: begin
          if (!start) begin
            state_q <= PAUSE;
          end else if (term_s) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (load) begin
            grid_q      <= seed;
            gen_count_q <= '0;
            stable_q    <= 1'b0;
            state_q     <= PAUSE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grid      = grid_q;
  assign gen_count = gen_count_q;
  assign stable    = stable_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign en        = adv_s;

endmodule

// File: tb/tb_life_engine.sv
// Directed table-driven bench for life_engine: a toroidal and a dead-border
// instance share the same stimulus, expectations are hand-computed patterns.
module tb_life_engine;

  localparam int R  = 16;
  localparam int C  = 16;
  localparam int N  = R * C;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, clear, load, start, step;
  logic [N-1:0]  seed;
  logic [CW-1:0] gen_limit;

  logic [N-1:0]  grid_w, grid_n;
  logic [CW-1:0] cnt_w, cnt_n;
  logic          en_w, en_n, busy_w, busy_n, done_w, done_n, stable_w, stable_n;

  life_engine #(.ROWS(R), .COLS(C), .WRAP(1), .CNT_W(CW)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .seed(seed),
    .start(start), .step(step), .gen_limit(gen_limit), .grid(grid_w),
    .gen_count(cnt_w), .en(en_w), .busy(busy_w), .done(done_w), .stable(stable_w)
  );

  life_engine #(.ROWS(R), .COLS(C), .WRAP(0), .CNT_W(CW)) u_nowrap (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .seed(seed),
    .start(start), .step(step), .gen_limit(gen_limit), .grid(grid_n),
    .gen_count(cnt_n), .en(en_n), .busy(busy_n), .done(done_n), .stable(stable_n)
  );

  typedef struct {
    logic          rst_n, clr, ld, stp, sta;
    logic [CW-1:0] lim;
    logic [N-1:0]  sd, eg, egn;
    logic [CW-1:0] ecnt;
    logic          een, ebusy, edone, estab;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic [N-1:0] Z, BH, BV, E, EW, EN, BLK;

  function automatic logic [N-1:0] pt(input int r, input int c);
    logic [N-1:0] v;
    v = '0;
    v[r*C+c] = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(input int rst_n, input int clr, input int ld, input int stp,
                              input int sta, input int lim, input logic [N-1:0] sd,
                              input logic [N-1:0] eg, input logic [N-1:0] egn, input int ecnt,
                              input int een, input int ebusy, input int edone, input int estab);
    vec_t v;
    v.rst_n = 1'(rst_n); v.clr = 1'(clr); v.ld = 1'(ld); v.stp = 1'(stp); v.sta = 1'(sta);
    v.lim = CW'(lim); v.sd = sd; v.eg = eg; v.egn = egn; v.ecnt = CW'(ecnt);
    v.een = 1'(een); v.ebusy = 1'(ebusy); v.edone = 1'(edone); v.estab = 1'(estab);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    reset = v.rst_n; clear = v.clr; load = v.ld; step = v.stp; start = v.sta;
    gen_limit = v.lim; seed = v.sd;
    #1;
    chk("en_wrap", idx, N'(en_w), N'(v.een));
    chk("en_nowrap", idx, N'(en_n), N'(v.een));
    @(posedge clk);
    #1;
    chk("grid_wrap", idx, grid_w, v.eg);
    chk("grid_nowrap", idx, grid_n, v.egn);
    chk("gen_count_wrap", idx, N'(cnt_w), N'(v.ecnt));
    chk("gen_count_nowrap", idx, N'(cnt_n), N'(v.ecnt));
    chk("busy", idx, N'({busy_w, busy_n}), N'({v.ebusy, v.ebusy}));
    chk("done", idx, N'({done_w, done_n}), N'({v.edone, v.edone}));
    chk("stable", idx, N'({stable_w, stable_n}), N'({v.estab, v.estab}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt;
    reset = 1'b0; clear = 1'b0; load = 1'b0; start = 1'b0; step = 1'b0;
    seed = '0; gen_limit = '0;

    Z   = '0;
    BH  = pt(5,4) | pt(5,5) | pt(5,6);
    BV  = pt(4,5) | pt(5,5) | pt(6,5);
    E   = pt(0,7) | pt(0,8) | pt(0,9);
    EW  = pt(15,8) | pt(0,8) | pt(1,8);
    EN  = pt(0,8) | pt(1,8);
    BLK = pt(2,2) | pt(2,3) | pt(3,2) | pt(3,3);

    //               rst clr ld stp sta lim seed  grid_w grid_n cnt en bsy dn st
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, Z,   Z,   Z,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, BH,  BH,  BH,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, Z,   BV,  BV,  1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, Z,   BV,  BV,  1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, Z,   BH,  BH,  2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, E,   E,   E,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, Z,   EW,  EN,  1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, Z,   E,   Z,   2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, Z,   Z,   Z,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 5, BH,  BH,  BH,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5, Z,   BH,  BH,  0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5, Z,   BV,  BV,  1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5, Z,   BH,  BH,  2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5, Z,   BV,  BV,  3, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5, Z,   BH,  BH,  4, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5, Z,   BV,  BV,  5, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5, Z,   BV,  BV,  5, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 5, Z,   BV,  BV,  5, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, Z,   Z,   Z,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, BLK, BLK, BLK, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, Z,   BLK, BLK, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, Z,   BLK, BLK, 1, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, BH,  BH,  BH,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, Z,   BH,  BH,  0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, Z,   BV,  BV,  1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, Z,   BH,  BH,  2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, Z,   BV,  BV,  3, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, Z,   BV,  BV,  3, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, Z,   BV,  BV,  3, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, BLK, BH,  BH,  4, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, Z,   BV,  BV,  5, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, Z,   Z,   Z,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, BH,  BH,  BH,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, Z,   BH,  BH,  0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, Z,   BV,  BV,  1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, Z,   Z,   Z,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, Z,   Z,   Z,   0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Limit run with start held: count enable cycles until done, bounded.
    reset = 1'b1; clear = 1'b1; load = 1'b0; step = 1'b0; start = 1'b0; gen_limit = '0;
    @(posedge clk); #1;
    clear = 1'b0; load = 1'b1; seed = BH; gen_limit = CW'(5);
    @(posedge clk); #1;
    load = 1'b0; start = 1'b1;
    en_cnt = 0;
    for (int k = 0; k < 20 && !done_w; k++) begin
      #1;
      if (en_w) en_cnt++;
      @(posedge clk); #1;
    end
    chk("limit_done", 100, N'(done_w), N'(1'b1));
    chk("limit_en_cycles", 100, N'(en_cnt), N'(5));
    chk("limit_gen_count", 100, N'(cnt_w), N'(5));
    chk("limit_grid", 100, grid_w, BV);

    // A single step with gen_limit=1 terminates straight from IDLE.
    start = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; load = 1'b1; seed = BH; gen_limit = CW'(1);
    @(posedge clk); #1;
    load = 1'b0; step = 1'b1;
    #1;
    chk("lim1_en", 101, N'(en_w), N'(1'b1));
    @(posedge clk); #1;
    step = 1'b0;
    chk("lim1_done", 101, N'(done_w), N'(1'b1));
    chk("lim1_gen_count", 101, N'(cnt_w), N'(1));
    chk("lim1_grid", 101, grid_w, BV);
    chk("lim1_stable", 101, N'(stable_w), N'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
